pwm_fader: RTL and testbench

// Upstream stage of the PWM block: owns the pulse-width and period words that feed it.

---
 rtl/pwm_fader.sv | 120 ++++++++++++
 tb/tb_pwm_fader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_fader.sv
// rtl/pwm_fader.sv - ramps the PWM pulse width toward a requested target in fixed steps
// Requests are accepted over valid/ready while idle; max_counter_o updates only at accept.
module pwm_fader #(
    parameter int CtrSize   = 8,
    parameter int PrescSize = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 target_valid_i,
    output logic                 target_ready_o,
    input  logic [CtrSize-1:0]   target_i,
    input  logic [CtrSize-1:0]   period_i,
    input  logic [CtrSize-1:0]   step_i,
    input  logic [PrescSize-1:0] interval_i,
    input  logic                 abort_i,
    output logic [CtrSize-1:0]   pulse_width_o,
    output logic [CtrSize-1:0]   max_counter_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t               state, state_next;
    logic [CtrSize-1:0]   pulse_width_q, max_counter_q, target_q, step_q;
    logic [PrescSize-1:0] interval_q, presc_q;
    logic                 done_q;
    logic                 accept, tick, at_target;
    logic [CtrSize:0]     diff;

    assign target_ready_o = (state == IDLE) & rst_ni;
    assign accept         = target_valid_i & target_ready_o;
    assign tick           = (state == RAMP) && (presc_q == '0);

    // Distance is taken one bit wider so the compare against step never wraps.
    always_comb begin
        diff = '0;
        if ({1'b0, target_q} >= {1'b0, pulse_width_q}) begin
            diff = {1'b0, target_q} - {1'b0, pulse_width_q};
        end else begin
            diff = {1'b0, pulse_width_q} - {1'b0, target_q};
        end
    end

    assign at_target = (diff <= {1'b0, step_q});

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (target_i != pulse_width_q)) begin
                    state_next = RAMP;
                end
            end
            RAMP: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (tick && at_target) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= IDLE;
            pulse_width_q <= '0;
            max_counter_q <= '0;
            target_q      <= '0;
            step_q        <= '0;
            interval_q    <= '0;
            presc_q       <= '0;
            done_q        <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        target_q      <= target_i;
                        step_q        <= (step_i == '0) ? CtrSize'(1) : step_i;
                        interval_q    <= interval_i;
                        max_counter_q <= period_i;
                        presc_q       <= interval_i;
                        if (target_i == pulse_width_q) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    // Abort wins over a coincident tick: width and done stay untouched.
                    if (!abort_i) begin
                        if (tick) begin
                            presc_q <= interval_q;
                            if (at_target) begin
                                pulse_width_q <= target_q;
                                done_q        <= 1'b1;
                            end else if (target_q > pulse_width_q) begin
                                pulse_width_q <= pulse_width_q + step_q;
                            end else begin
                                pulse_width_q <= pulse_width_q - step_q;
                            end
                        end else begin
                            presc_q <= presc_q - PrescSize'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pulse_width_o = pulse_width_q;
    assign max_counter_o = max_counter_q;
    assign busy_o        = (state == RAMP);
    assign done_o        = done_q;

endmodule

// File: tb/tb_pwm_fader.sv
// tb/tb_pwm_fader.sv - randomized scoreboard bench for pwm_fader
// Expected width/done events are queued at accept and matched by a monitor on each change.
module tb_pwm_fader;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        target_valid_i = 1'b0;
    logic        target_ready_o;
    logic [7:0]  target_i = '0;
    logic [7:0]  period_i = '0;
    logic [7:0]  step_i = '0;
    logic [15:0] interval_i = '0;
    logic        abort_i = 1'b0;
    logic [7:0]  pulse_width_o;
    logic [7:0]  max_counter_o;
    logic        busy_o;
    logic        done_o;

    pwm_fader #(.CtrSize(8), .PrescSize(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .target_valid_i(target_valid_i), .target_ready_o(target_ready_o),
        .target_i(target_i), .period_i(period_i), .step_i(step_i),
        .interval_i(interval_i), .abort_i(abort_i),
        .pulse_width_o(pulse_width_o), .max_counter_o(max_counter_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int pw;
        bit done;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  compared = 0;
    int  mismatched = 0;
    int  model_pw = 0;
    int  prev_pw = 0;
    bit  mon_off = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Any width change or done pulse is a DUT output event matched against the queue.
    always @(negedge clk) begin
        if (!mon_off) begin
            if ((int'(pulse_width_o) != prev_pw) || done_o) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_event: width %0d done %0b at cycle %0d",
                             pulse_width_o, done_o, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.pw != int'(pulse_width_o) || e.done != done_o) begin
                        mismatched++;
                        $display("FAIL event: got width %0d done %0b cycle %0d, expected width %0d done %0b cycle %0d",
                                 pulse_width_o, done_o, cyc, e.pw, e.done, e.cyc);
                    end
                end
            end
        end
        prev_pw = int'(pulse_width_o);
    end

    task automatic apply_reset();
        mon_off = 1'b1;
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("ready_in_reset", int'(target_ready_o), 0);
        @(negedge clk);
        check("reset_width", int'(pulse_width_o), 0);
        check("reset_max_counter", int'(max_counter_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_done", int'(done_o), 0);
        rst_ni = 1'b1;
        #1;
        check("ready_after_reset", int'(target_ready_o), 1);
        exp_q.delete();
        model_pw = 0;
        prev_pw = 0;
        mon_off = 1'b0;
    endtask

    // mode: 0 none, 1 abort on final tick, 2 abort at random point, 3 reset at random point
    task automatic do_req(input int tgt, input int per, input int stp, input int intv,
                          input int mode, input bit abort_at_accept);
        ev_t evs[$];
        int  a, guard, x, s, p, k, d;
        @(negedge clk);
        target_i = 8'(tgt); period_i = 8'(per); step_i = 8'(stp);
        interval_i = 16'(intv); target_valid_i = 1'b1; abort_i = abort_at_accept;
        guard = 0;
        while (!target_ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("ready_timeout", 0, 1);
        a = cyc + 1;
        s = (stp == 0) ? 1 : stp;
        if (tgt == model_pw) begin
            evs.push_back('{cyc: a, pw: tgt, done: 1'b1});
            mode = 0;
        end else begin
            p = model_pw;
            k = 1;
            while (p != tgt) begin
                d = (tgt > p) ? tgt - p : p - tgt;
                if (d <= s) p = tgt;
                else p = (tgt > p) ? p + s : p - s;
                evs.push_back('{cyc: a + k * (intv + 1), pw: p, done: (p == tgt)});
                k++;
            end
        end
        x = 0;
        if (mode == 1) x = evs[evs.size()-1].cyc - 1;
        if (mode >= 2) x = $urandom_range(evs[evs.size()-1].cyc - 1, a);
        if (mode == 3) begin
            // Reset discards the whole ramp; apply_reset clears the queue.
            foreach (evs[i]) exp_q.push_back(evs[i]);
        end else begin
            foreach (evs[i]) begin
                if (mode == 0 || evs[i].cyc < x + 1) begin
                    exp_q.push_back(evs[i]);
                    model_pw = evs[i].pw;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        target_valid_i = 1'b0;
        abort_i = 1'b0;
        check("max_counter_at_accept", int'(max_counter_o), per);
        if (tgt == int'(prev_pw) && mode == 0 && evs.size() == 1 && evs[0].cyc == a)
            check("busy_equal_target", int'(busy_o), 0);
        if (mode != 0) begin
            while (cyc < x) begin
                @(negedge clk);
                target_valid_i = busy_o;
            end
            target_valid_i = 1'b0;
            if (mode == 3) begin
                apply_reset();
                return;
            end
            abort_i = 1'b1;
            @(negedge clk);
            abort_i = 1'b0;
        end
        guard = 0;
        while ((busy_o || exp_q.size() != 0) && guard < 3000) begin
            target_valid_i = busy_o;
            @(negedge clk);
            guard++;
        end
        target_valid_i = 1'b0;
        if (guard >= 3000) check("completion_timeout", 0, 1);
        @(negedge clk);
        check("idle_busy", int'(busy_o), 0);
        check("idle_ready", int'(target_ready_o), 1);
        check("final_width", int'(pulse_width_o), model_pw);
        check("max_counter_held", int'(max_counter_o), per);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        apply_reset();
        do_req(200, 255, 50, 3, 0, 1'b0);
        do_req(10, 255, 64, 2, 0, 1'b0);
        do_req(0, 255, 255, 0, 0, 1'b0);
        do_req(3, 100, 0, 1, 0, 1'b0);
        do_req(3, 120, 5, 2, 0, 1'b1);
        do_req(250, 200, 40, 1, 1, 1'b0);
        do_req(30, 255, 7, 2, 3, 1'b0);
        for (int i = 0; i < 30; i++) begin
            int m;
            m = $urandom_range(9, 0);
            do_req($urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(63, 0),
                   $urandom_range(3, 0), (m < 6) ? 0 : (m < 8) ? 2 : (m < 9) ? 1 : 3,
                   1'($urandom_range(1, 0)) && (m < 6));
        end
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
